pe_triplet_dispatcher: RTL
==========================

Name: pe_triplet_dispatcher

Overview:
Initiator side of the PE reducer handshake.
- Accepts a valid/ready stream of sparse nonzero entries, each an (xyz address, weight, activation) tuple.
- Packs entries into groups of three and presents each group with a one-cycle o_start pulse.
- Holds the group stable until the reducer returns i_finish.
- Pads a short tail group so the reducer merges the padding into an existing output and it contributes zero.

Parameters:
ADDR_BITS, 7, bits per coordinate (3 coordinates per address)
DATA_BITS, 16, signed width of weight and activation
GROUP, 3, entries per issued group (fixed at 3; reducer contract)

Ports:
i_clk  in  1  clock
i_rst  in  1  reset; synchronous, active-high
i_valid  in  1  input entry valid
o_ready  out  1  dispatcher can accept an entry
i_addr  in  3xADDR_BITS  entry coordinate triple
i_w  in  DATA_BITS signed  entry weight
i_ia  in  DATA_BITS signed  entry activation
i_last  in  1  entry is last of stream
o_start  out  1  one-cycle pulse: group valid on o_addr/o_w/o_ia
o_addr  out  GROUP x 3xADDR_BITS  group addresses, slot 0 first
o_w  out  GROUP x DATA_BITS signed  group weights
o_ia  out  GROUP x DATA_BITS signed  group activations
i_finish  in  1  reducer completed current group
o_busy  out  1  high from first accept of a stream until o_done
o_done  out  1  one-cycle pulse after final group's i_finish

Behaviour:
- One clock i_clk; reset synchronous, active-high, on i_rst.
- Reset state: FILL, slot count 0, last_seen 0, issued_any 0.
- Reset outputs: o_start=0, o_done=0, o_busy=0, o_ready=0 in the reset cycle, all slots and o_addr/o_w/o_ia = 0.
- Reset mid-operation, in any state, discards the partial group and any pending wait.

States:
- FILL:
  - o_ready=1.
  - Accept when i_valid & o_ready; write the entry to slot[cnt] and increment cnt.
  - If the accept fills slot 2, go to ISSUE.
  - If the accepted entry has i_last, pad slots cnt+1..2 and go to ISSUE with last_seen=1.
- ISSUE:
  - o_start=1 for exactly one cycle, o_ready=0; go to WAIT.
  - The group is issued the cycle after the accept that completed it.
- WAIT:
  - o_ready=0; outputs hold.
  - On i_finish: if last_seen, go to DONE; else go to FILL with cnt=0.
- DONE:
  - o_done=1 for one cycle; clear last_seen, issued_any and o_busy; go to FILL.

Padding:
- Pad slot address = address of the last real slot (slot cnt-1 after accept); pad w=0, ia=0.
- Reducer therefore merges the pad into the same output with product 0.

Boundary conditions:
- i_finish outside WAIT is ignored (no state change).
- i_finish in the same cycle as o_start is ignored.
- i_valid while o_ready=0 is not consumed; the source must hold it.
- i_last on the third entry of a group: no padding; normal issue, then DONE after finish.
- i_w/i_ia are passed through unaltered. The 32-bit product and 34-bit sums are the reducer's concern; the dispatcher does no arithmetic beyond counters.
- cnt is 2 bits and never exceeds 2 at a write.

Optional Feature:
PE_DISPATCH_SKIP_ZERO_EN
- Defined:
  - An accepted entry with i_w==0 or i_ia==0 is consumed (o_ready handshake completes) but not written; cnt unchanged.
  - If that entry carries i_last with cnt>0: pad and ISSUE.
  - If it carries i_last with cnt==0: go straight to DONE (no empty group issued), whether or not earlier groups were issued.
- Undefined: zero-valued entries are dispatched like any other.

Decomposition:
- Shared package pe_pkg:
  - ADDR_BITS, DATA_BITS, GROUP localparams
  - typedef coord_t = logic [2:0][ADDR_BITS-1:0]
  - typedef data_t = logic signed [DATA_BITS-1:0]
  - dispatcher state enum (FILL, ISSUE, WAIT, DONE)
- Sub-module triplet_stage:
  - 3-slot register file with write-at-index and a pad-from-index operation.
  - Drives o_addr/o_w/o_ia directly.
- The top holds the FSM and counters.

Test Plan:
- Full group: entries (1,1,1,w=2,ia=3), (1,1,2,w=4,ia=5), (2,0,0,w=-1,ia=7) on 3 consecutive cycles -> o_start high exactly the 4th cycle; o_ready low until i_finish; outputs unchanged while waiting.
- Tail of one: single entry (3,4,5,w=6,ia=-2) with i_last -> slots 1,2 = addr (3,4,5), w=0, ia=0; o_start; after i_finish, o_done pulses next cycle; o_busy drops.
- Backpressure/gaps: 7 entries with i_valid gaps, last on the 7th -> groups {1,2,3}, {4,5,6}, {7,pad,pad}; exactly 3 o_start pulses; no entry lost or duplicated.
- Spurious finish: i_finish asserted in FILL, and again coincident with o_start -> no state change; a later i_finish in WAIT completes the group.
- Reset mid-WAIT: i_rst high one cycle during WAIT -> next cycle all outputs 0, state FILL; a fresh group then issues normally.
- PE_DISPATCH_SKIP_ZERO_EN: stream (w=5,ia=1), (w=0,ia=9), (w=2,ia=0,last) -> one group {entry1, pad, pad}, then o_done. A single zero entry with last -> o_done with no o_start.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared types and constants for the PE triplet dispatcher.
// Optional build macro PE_DISPATCH_SKIP_ZERO_EN is consumed by pe_triplet_dispatcher.
package pe_pkg;

  localparam int ADDR_BITS = 7;
  localparam int DATA_BITS = 16;
  localparam int GROUP     = 3;

  // Highest slot index of a group; filling it closes the group.
  localparam logic [1:0] LAST_SLOT = 2'(GROUP - 1);

  // Coordinate triple: [0]=x, [1]=y, [2]=z.
  typedef logic [2:0][ADDR_BITS-1:0] coord_t;
  typedef logic signed [DATA_BITS-1:0] data_t;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } disp_state_t;

endpackage

// File: rtl/triplet_stage.sv
// Three-slot register file holding the group presented to the reducer.
// Supports a write at one index and, in the same cycle, padding of every
// slot above a given index with that slot's address and zero data.
module triplet_stage
  import pe_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [1:0]            wr_idx,
  input  coord_t                wr_addr,
  input  data_t                 wr_w,
  input  data_t                 wr_ia,
  input  logic                  pad_en,
  input  logic [1:0]            pad_from,
  output coord_t [GROUP-1:0]    slot_addr,
  output data_t  [GROUP-1:0]    slot_w,
  output data_t  [GROUP-1:0]    slot_ia
);

  coord_t pad_addr;

  // Pad address comes from the entry being written this cycle when it lands
  // on the pad source slot, otherwise from the already stored slot.
  always_comb begin
    pad_addr = slot_addr[pad_from];
    if (wr_en && (wr_idx == pad_from)) begin
      pad_addr = wr_addr;
    end
  end

  // Slot storage: write-at-index has priority, padding fills slots above pad_from.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_addr <= '0;
      slot_w    <= '0;
      slot_ia   <= '0;
    end else begin
      for (int i = 0; i < GROUP; i++) begin
        if (wr_en && (wr_idx == 2'(i))) begin
          slot_addr[i] <= wr_addr;
          slot_w[i]    <= wr_w;
          slot_ia[i]   <= wr_ia;
        end else if (pad_en && (2'(i) > pad_from)) begin
          slot_addr[i] <= pad_addr;
          slot_w[i]    <= '0;
          slot_ia[i]   <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/pe_triplet_dispatcher.sv
// Initiator side of the PE reducer handshake: packs a stream of sparse
// entries into groups of three, issues each with a one-cycle o_start and
// holds it until i_finish. Short tail groups are padded with zero-data
// copies of the last real address so the padding contributes nothing.
// Optional macro PE_DISPATCH_SKIP_ZERO_EN: entries with a zero weight or
// activation are consumed but never stored.
module pe_triplet_dispatcher
  import pe_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  coord_t               i_addr,
  input  data_t                i_w,
  input  data_t                i_ia,
  input  logic                 i_last,
  output logic                 o_start,
  output coord_t [GROUP-1:0]   o_addr,
  output data_t  [GROUP-1:0]   o_w,
  output data_t  [GROUP-1:0]   o_ia,
  input  logic                 i_finish,
  output logic                 o_busy,
  output logic                 o_done
);

  disp_state_t state;
  logic [1:0]  cnt;
  logic        last_seen;
  logic        issued_any;
  logic        busy_r;

  logic        accept;
  logic        skip;
  logic        wr_en;
  logic        pad_en;
  logic [1:0]  pad_from;

`ifdef PE_DISPATCH_SKIP_ZERO_EN
  assign skip = (i_w == '0) || (i_ia == '0);
`else
  assign skip = 1'b0;
`endif

  assign accept = i_valid && o_ready;
  assign wr_en  = accept && !skip;
  // A skipped last entry pads from the previous real slot; with nothing
  // stored there is no group to pad.
  assign pad_en   = accept && i_last && (!skip || (cnt != 2'd0));
  assign pad_from = skip ? (cnt - 2'd1) : cnt;

  // Busy covers the whole stream, including the gaps between groups.
  assign o_busy = busy_r || issued_any;

  triplet_stage u_stage (
    .clk       (i_clk),
    .rst       (i_rst),
    .wr_en     (wr_en),
    .wr_idx    (cnt),
    .wr_addr   (i_addr),
    .wr_w      (i_w),
    .wr_ia     (i_ia),
    .pad_en    (pad_en),
    .pad_from  (pad_from),
    .slot_addr (o_addr),
    .slot_w    (o_w),
    .slot_ia   (o_ia)
  );

  // Dispatcher FSM with registered handshake outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= FILL;
      cnt        <= 2'd0;
      last_seen  <= 1'b0;
      issued_any <= 1'b0;
      busy_r     <= 1'b0;
      o_start    <= 1'b0;
      o_done     <= 1'b0;
      o_ready    <= 1'b0;
    end else begin
      o_start <= 1'b0;
      o_done  <= 1'b0;
      case (state)
        FILL: begin
          o_ready <= 1'b1;
          if (accept) begin
            busy_r <= 1'b1;
            if (i_last && !wr_en && (cnt == 2'd0)) begin
              // Stream ended on a skipped entry with no pending group.
              state      <= DONE;
              o_done     <= 1'b1;
              o_ready    <= 1'b0;
              busy_r     <= 1'b0;
              issued_any <= 1'b0;
            end else if (i_last || (wr_en && (cnt == LAST_SLOT))) begin
              state      <= ISSUE;
              o_start    <= 1'b1;
              o_ready    <= 1'b0;
              issued_any <= 1'b1;
              last_seen  <= i_last;
            end else if (wr_en) begin
              cnt <= cnt + 2'd1;
            end
          end
        end
        ISSUE: begin
          // i_finish coincident with o_start is deliberately not looked at.
          state <= WAIT;
        end
        WAIT: begin
          if (i_finish) begin
            cnt <= 2'd0;
            if (last_seen) begin
              state      <= DONE;
              o_done     <= 1'b1;
              busy_r     <= 1'b0;
              issued_any <= 1'b0;
            end else begin
              state   <= FILL;
              o_ready <= 1'b1;
            end
          end
        end
        DONE: begin
          last_seen  <= 1'b0;
          issued_any <= 1'b0;
          busy_r     <= 1'b0;
          state      <= FILL;
          o_ready    <= 1'b1;
        end
        default: begin
          state <= FILL;
        end
      endcase
    end
  end

endmodule
